// File: rtl/vga_sync_porch_pattern_pkg.sv
// Shared VGA timing constants, the test-pattern enumeration and the
// colour-bar index helper. Used by the sync generator and this stage.
package vga_pkg;

    // 640x480 @ 60 Hz default timing
    localparam int TOTAL_COLS    = 800;
    localparam int TOTAL_ROWS    = 525;
    localparam int ACTIVE_COLS   = 640;
    localparam int ACTIVE_ROWS   = 480;
    localparam int H_FRONT_PORCH = 16;
    localparam int H_SYNC_WIDTH  = 96;
    localparam int V_FRONT_PORCH = 10;
    localparam int V_SYNC_WIDTH  = 2;
    localparam int VIDEO_WIDTH   = 3;

    localparam int CNT_WIDTH = 10;
    localparam int FC_WIDTH  = 8;

    // Inclusive sync pulse windows, expressed at counter width
    localparam logic [CNT_WIDTH-1:0] H_SYNC_FIRST = CNT_WIDTH'(ACTIVE_COLS + H_FRONT_PORCH);
    localparam logic [CNT_WIDTH-1:0] H_SYNC_LAST  = CNT_WIDTH'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
    localparam logic [CNT_WIDTH-1:0] V_SYNC_FIRST = CNT_WIDTH'(ACTIVE_ROWS + V_FRONT_PORCH);
    localparam logic [CNT_WIDTH-1:0] V_SYNC_LAST  = CNT_WIDTH'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);

    // Last visible column/row, used by the border pattern
    localparam logic [CNT_WIDTH-1:0] COL_LAST = CNT_WIDTH'(ACTIVE_COLS - 1);
    localparam logic [CNT_WIDTH-1:0] ROW_LAST = CNT_WIDTH'(ACTIVE_ROWS - 1);

    localparam int BAR_WIDTH = ACTIVE_COLS / 8;

    typedef enum logic [2:0] {
        PAT_BLACK   = 3'd0,
        PAT_WHITE   = 3'd1,
        PAT_BARS    = 3'd2,
        PAT_CHECKER = 3'd3,
        PAT_BORDER  = 3'd4,
        PAT_SCROLL  = 3'd5,
        PAT_RSVD6   = 3'd6,
        PAT_RSVD7   = 3'd7
    } pattern_e;

    // Bar index 0..7 from a chain of constant compares; columns past the
    // last bar boundary land in bar 7.
    function automatic logic [2:0] bar_index(input logic [CNT_WIDTH-1:0] col);
        logic [2:0] b;
        b = 3'd7;
        for (int i = 7; i >= 1; i--) begin
            if (col < CNT_WIDTH'(i * BAR_WIDTH)) begin
                b = 3'(i - 1);
            end
        end
        return b;
    endfunction

endpackage

// File: rtl/vga_sync_porch_pattern_if.sv
// Pixel-stream bundle between the sync generator / sink and the
// porch+pattern stage.
// Flow control: none. The stream advances one pixel per clock with no
// valid/ready pair and no backpressure; every clock carries a pixel.
interface vga_sync_porch_pattern_if;
    import vga_pkg::*;

    logic                   hsync_in;
    logic                   vsync_in;
    logic [CNT_WIDTH-1:0]   col_in;
    logic [CNT_WIDTH-1:0]   row_in;
    logic [2:0]             pattern_sel;

    logic                   hsync_out;
    logic                   vsync_out;
    logic                   de_out;
    logic [VIDEO_WIDTH-1:0] red;
    logic [VIDEO_WIDTH-1:0] grn;
    logic [VIDEO_WIDTH-1:0] blu;
    logic [FC_WIDTH-1:0]    frame_count;

    // Side that feeds counters and consumes video
    modport master (
        output hsync_in, vsync_in, col_in, row_in, pattern_sel,
        input  hsync_out, vsync_out, de_out, red, grn, blu, frame_count
    );

    // The porch/pattern stage itself
    modport slave (
        input  hsync_in, vsync_in, col_in, row_in, pattern_sel,
        output hsync_out, vsync_out, de_out, red, grn, blu, frame_count
    );

endinterface

// File: rtl/vga_sync_porch_pattern_rgb.sv
// Combinational test-pattern generator: (col, row, frame_count, pattern)
// to raw RGB. Blanking is applied by the caller.
module vga_pattern_rgb
    import vga_pkg::*;
(
    input  logic [CNT_WIDTH-1:0]   col,
    input  logic [CNT_WIDTH-1:0]   row,
    input  logic [FC_WIDTH-1:0]    frame_count,
    input  pattern_e               pattern,
    output logic [VIDEO_WIDTH-1:0] red,
    output logic [VIDEO_WIDTH-1:0] grn,
    output logic [VIDEO_WIDTH-1:0] blu
);

    logic [CNT_WIDTH-1:0] scroll_col;
    logic [2:0]           bar;
    logic                 white;

    // Select the pixel colour for the active pattern
    always_comb begin
        scroll_col = col + CNT_WIDTH'(frame_count);
        bar        = bar_index(col);
        white      = 1'b0;
        red        = '0;
        grn        = '0;
        blu        = '0;
        case (pattern)
            PAT_WHITE:   white = 1'b1;
            PAT_CHECKER: white = col[5] ^ row[5];
            PAT_BORDER:  white = (col == '0) || (col == COL_LAST) ||
                                 (row == '0) || (row == ROW_LAST);
            PAT_SCROLL:  white = scroll_col[5] ^ row[5];
            PAT_BARS: begin
                red = {VIDEO_WIDTH{bar[2]}};
                grn = {VIDEO_WIDTH{bar[1]}};
                blu = {VIDEO_WIDTH{bar[0]}};
            end
            default:     white = 1'b0;
        endcase
        if (white) begin
            red = '1;
            grn = '1;
            blu = '1;
        end
    end

endmodule

// File: rtl/vga_sync_porch_pattern.sv
// Porch/sync/pattern stage: turns the sync generator's active-region flags
// into real active-low syncs and a gated test pattern. Two register stages,
// every output delayed by exactly two clocks from its inputs.
module vga_sync_porch_pattern
    import vga_pkg::*;
(
    input  logic clk,
    input  logic rst_n,
    vga_sync_porch_pattern_if.slave bus
);

    // Stage 1: registered copies of the incoming stream
    logic                   s1_valid;
    logic                   s1_hact;
    logic                   s1_vact;
    logic [CNT_WIDTH-1:0]   s1_col;
    logic [CNT_WIDTH-1:0]   s1_row;
    pattern_e               s1_sel;

    // Frame-level state
    pattern_e               active_pat;
    logic [FC_WIDTH-1:0]    frame_cnt;

    // Stage 2: output registers
    logic                   s2_hsync;
    logic                   s2_vsync;
    logic                   s2_de;
    logic [VIDEO_WIDTH-1:0] s2_red;
    logic [VIDEO_WIDTH-1:0] s2_grn;
    logic [VIDEO_WIDTH-1:0] s2_blu;

    // Decode between the stages
    logic                   frame_start;
    logic                   s1_de;
    logic                   hsync_next;
    logic                   vsync_next;
    pattern_e               pat_next;
    logic [FC_WIDTH-1:0]    fc_next;
    logic [VIDEO_WIDTH-1:0] pat_red;
    logic [VIDEO_WIDTH-1:0] pat_grn;
    logic [VIDEO_WIDTH-1:0] pat_blu;

    // Capture the input stream; s1_valid keeps the reset contents of stage 1
    // from looking like a (0,0) frame start on the first clock after reset.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s1_valid <= 1'b0;
            s1_hact  <= 1'b0;
            s1_vact  <= 1'b0;
            s1_col   <= '0;
            s1_row   <= '0;
            s1_sel   <= PAT_BLACK;
        end else begin
            s1_valid <= 1'b1;
            s1_hact  <= bus.hsync_in;
            s1_vact  <= bus.vsync_in;
            s1_col   <= bus.col_in;
            s1_row   <= bus.row_in;
            s1_sel   <= pattern_e'(bus.pattern_sel);
        end
    end

    // Frame-start handling and sync decode; the first pixel of a frame
    // already uses the newly selected pattern and the incremented count.
    always_comb begin
        frame_start = s1_valid && (s1_col == '0) && (s1_row == '0);
        pat_next    = active_pat;
        fc_next     = frame_cnt;
        if (frame_start) begin
            pat_next = s1_sel;
            fc_next  = frame_cnt + FC_WIDTH'(1);
        end
        s1_de      = s1_hact & s1_vact;
        hsync_next = !((s1_col >= H_SYNC_FIRST) && (s1_col <= H_SYNC_LAST));
        vsync_next = !((s1_row >= V_SYNC_FIRST) && (s1_row <= V_SYNC_LAST));
    end

    vga_pattern_rgb u_pattern_rgb (
        .col         (s1_col),
        .row         (s1_row),
        .frame_count (fc_next),
        .pattern     (pat_next),
        .red         (pat_red),
        .grn         (pat_grn),
        .blu         (pat_blu)
    );

    // Output registers and frame state; colour is forced to black when blanked
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            s2_hsync   <= 1'b1;
            s2_vsync   <= 1'b1;
            s2_de      <= 1'b0;
            s2_red     <= '0;
            s2_grn     <= '0;
            s2_blu     <= '0;
            active_pat <= PAT_BLACK;
            frame_cnt  <= '0;
        end else begin
            s2_hsync   <= hsync_next;
            s2_vsync   <= vsync_next;
            s2_de      <= s1_de;
            s2_red     <= s1_de ? pat_red : '0;
            s2_grn     <= s1_de ? pat_grn : '0;
            s2_blu     <= s1_de ? pat_blu : '0;
            active_pat <= pat_next;
            frame_cnt  <= fc_next;
        end
    end

    assign bus.hsync_out   = s2_hsync;
    assign bus.vsync_out   = s2_vsync;
    assign bus.de_out      = s2_de;
    assign bus.red         = s2_red;
    assign bus.grn         = s2_grn;
    assign bus.blu         = s2_blu;
    assign bus.frame_count = frame_cnt;

endmodule

// File: tb/tb_vga_sync_porch_pattern.sv
// Directed bench for vga_sync_porch_pattern: a reference model predicts each
// pixel's outputs as it is driven, the prediction is queued and compared
// two clocks later when the DUT presents that pixel.
module tb_vga_sync_porch_pattern;
    import vga_pkg::*;

    localparam int W = 20;  // {hsync, vsync, de, red, grn, blu, frame_count}

    // Clock and reset
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    vga_sync_porch_pattern_if bus ();

    vga_sync_porch_pattern dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    // Scoreboard state
    logic [W-1:0] exp_q[$];
    int           id_q[$];
    int           checks = 0;
    int           passed = 0;
    int           fails  = 0;
    int           step   = 0;

    // Reference model frame state
    logic [2:0]   m_pat;
    logic [7:0]   m_fc;

    // Expected outputs for one pixel, from the current model frame state
    function automatic logic [W-1:0] model(input logic h, input logic v,
                                           input int col, input int row);
        logic       hs, vs, de, white;
        logic [2:0] r, g, b, bi;
        int         s;
        hs = !(col >= 656 && col <= 751);
        vs = !(row >= 490 && row <= 491);
        de = h & v;
        white = 1'b0;
        r = 3'd0; g = 3'd0; b = 3'd0;
        case (m_pat)
            3'd1: white = 1'b1;
            3'd2: begin
                bi = 3'(col / 80);
                r = {3{bi[2]}};
                g = {3{bi[1]}};
                b = {3{bi[0]}};
            end
            3'd3: white = ((col / 32) % 2 == 1) != ((row / 32) % 2 == 1);
            3'd4: white = (col == 0) || (col == 639) || (row == 0) || (row == 479);
            3'd5: begin
                s = (col + int'(m_fc)) % 1024;
                white = ((s / 32) % 2 == 1) != ((row / 32) % 2 == 1);
            end
            default: white = 1'b0;
        endcase
        if (white) begin
            r = 3'd7; g = 3'd7; b = 3'd7;
        end
        if (!de) begin
            r = 3'd0; g = 3'd0; b = 3'd0;
        end
        return {hs, vs, de, r, g, b, m_fc};
    endfunction

    // One comparison
    task automatic chk(input string name, input int id,
                       input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) passed++;
        else begin
            fails++;
            $error("FAIL %s step %0d: got %0h expected %0h", name, id, obs, expv);
        end
    endtask

    // Compare all DUT outputs against one expected record
    task automatic compare(input logic [W-1:0] e, input int id);
        chk("hsync", id, 32'(bus.hsync_out), 32'(e[19]));
        chk("vsync", id, 32'(bus.vsync_out), 32'(e[18]));
        chk("de",    id, 32'(bus.de_out),    32'(e[17]));
        chk("rgb",   id, 32'({bus.red, bus.grn, bus.blu}), 32'(e[16:8]));
        chk("fcnt",  id, 32'(bus.frame_count), 32'(e[7:0]));
    endtask

    // Outputs must show reset values right now
    task automatic chk_reset(input int id);
        compare({1'b1, 1'b1, 1'b0, 9'd0, 8'd0}, id);
    endtask

    // Non-frame-start input used whenever the stream is idle
    task automatic idle_inputs();
        bus.hsync_in    = 1'b0;
        bus.vsync_in    = 1'b1;
        bus.col_in      = 10'd700;
        bus.row_in      = 10'd10;
        bus.pattern_sel = 3'd0;
    endtask

    // Driver: compare the pixel from two clocks ago, then present a new one
    task automatic drive(input logic h, input logic v, input int col,
                         input int row, input int sel);
        @(negedge clk);
        if (exp_q.size() == 2) begin
            compare(exp_q.pop_front(), id_q.pop_front());
        end
        bus.hsync_in    = h;
        bus.vsync_in    = v;
        bus.col_in      = 10'(col);
        bus.row_in      = 10'(row);
        bus.pattern_sel = 3'(sel);
        step++;
        if (col == 0 && row == 0) begin
            m_pat = 3'(sel);
            m_fc  = m_fc + 8'd1;
        end
        exp_q.push_back(model(h, v, col, row));
        id_q.push_back(step);
    endtask

    // Drain the pipeline with idle inputs
    task automatic flush();
        while (exp_q.size() > 0) begin
            @(negedge clk);
            compare(exp_q.pop_front(), id_q.pop_front());
            idle_inputs();
        end
    endtask

    // Watchdog
    initial begin
        #1000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1);
    end

    initial begin
        idle_inputs();
        m_pat = 3'd0;
        m_fc  = 8'd0;

        // Reset: outputs take reset values immediately and hold them
        #2 rst_n = 1'b0;
        #1 chk_reset(0);
        repeat (3) @(negedge clk);
        chk_reset(0);
        rst_n = 1'b1;

        // Colour bars over one line, also covering the full hsync window
        drive(1, 1, 0, 0, 2);
        for (int c = 0; c < 800; c++) drive(c < 640, 1, c, 10, 2);
        flush();

        // Vsync window and out-of-range counters
        for (int r = 485; r < 496; r++) drive(1, r < 480, 10, r, 2);
        drive(0, 0, 1000, 1000, 2);
        drive(0, 0, 799, 524, 2);
        flush();

        // Frame-aligned select: white stays until the next frame start
        drive(1, 1, 0, 0, 1);
        for (int c = 0; c < 8; c++) drive(1, 1, c * 10, 50, 1);
        for (int c = 0; c < 8; c++) drive(1, 1, c * 10, 100, 3);
        drive(1, 1, 639, 479, 3);
        drive(1, 1, 0, 0, 3);
        for (int c = 1; c < 41; c++) drive(1, 1, c, 0, 3);
        flush();

        // Blanking with white pattern
        drive(1, 1, 0, 0, 1);
        drive(0, 1, 700, 10, 1);
        drive(1, 1, 639, 10, 1);
        drive(0, 1, 640, 10, 1);
        drive(1, 0, 100, 480, 1);
        // Reserved pattern codes are black
        drive(1, 1, 0, 0, 6);
        drive(1, 1, 100, 100, 6);
        drive(1, 1, 0, 0, 7);
        drive(1, 1, 200, 200, 7);
        flush();

        // Scrolling checkerboard at frame_count 32
        for (int i = 0; i < 256 && m_fc != 8'd31; i++) drive(1, 1, 0, 0, 0);
        drive(1, 1, 0, 0, 5);
        drive(1, 1, 32, 0, 5);
        drive(1, 1, 31, 0, 5);
        drive(1, 1, 0, 32, 5);
        drive(1, 1, 1000, 40, 5);
        // 256 frame starts bring the counter through 255 -> 0 and back
        for (int i = 0; i < 256; i++) drive(1, 1, 0, 0, 5);
        drive(1, 1, 5, 0, 5);
        flush();

        // Mid-line reset at column 300
        drive(1, 1, 0, 0, 1);
        for (int c = 290; c <= 300; c++) drive(1, 1, c, 10, 1);
        #2 rst_n = 1'b0;
        #1 chk_reset(step);
        exp_q.delete();
        id_q.delete();
        m_pat = 3'd0;
        m_fc  = 8'd0;
        bus.hsync_in    = 1'b1;
        bus.vsync_in    = 1'b1;
        bus.col_in      = 10'd301;
        bus.row_in      = 10'd10;
        bus.pattern_sel = 3'd4;
        repeat (2) @(negedge clk);
        chk_reset(step);
        rst_n = 1'b1;
        // Pattern 0 until the first frame start, then the border pattern
        for (int c = 302; c < 312; c++) drive(1, 1, c, 10, 4);
        drive(1, 1, 0, 0, 4);
        drive(1, 1, 5, 0, 4);
        drive(1, 1, 5, 5, 4);
        drive(1, 1, 639, 5, 4);
        drive(1, 1, 638, 5, 4);
        drive(1, 1, 100, 479, 4);
        drive(1, 1, 100, 478, 4);
        flush();

        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
